alu_sequencer: RTL and testbench

Multi-cycle controller that owns the ALU bus interface (aluFunc, busA, busB, aluEn, busD) and drives it from a small internal register file. A requester issues a command (function, source/destination registers, optional immediate, repeat count) over a valid/ready handshake. The block sequences operand load, ALU evaluation, result capture and write-back, and chains repeated passes. It sits between the instruction decode path and the combinational alu, replacing direct bench or decoder drive of the ALU buses.

---
 rtl/alu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU bus controller: latches a command, loads operands from an
// internal register file, captures the ALU result and writes it back, chaining passes.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int REGS  = 8,
    localparam int AW   = (REGS > 1) ? $clog2(REGS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmdValid,
    output logic                    cmdReady,
    input  logic [3:0]              cmdFunc,
    input  logic [AW-1:0]           cmdDst,
    input  logic [AW-1:0]           cmdSrcA,
    input  logic [AW-1:0]           cmdSrcB,
    input  logic                    cmdUseImm,
    input  logic signed [WIDTH-1:0] cmdImm,
    input  logic [3:0]              cmdCount,
    input  logic                    wrEn,
    input  logic [AW-1:0]           wrAddr,
    input  logic [WIDTH-1:0]        wrData,
    input  logic [AW-1:0]           rdAddr,
    output logic [WIDTH-1:0]        rdData,
    output logic [3:0]              aluFunc,
    output logic signed [WIDTH-1:0] busA,
    output logic signed [WIDTH-1:0] busB,
    output logic                    aluEn,
    input  logic signed [WIDTH-1:0] busD,
    output logic                    doneValid,
    output logic [WIDTH-1:0]        result,
    output logic                    zero,
    output logic                    neg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [3:0]              r_func;
    logic [AW-1:0]           r_dst;
    logic [AW-1:0]           r_src_a;
    logic [AW-1:0]           r_src_b;
    logic                    r_use_imm;
    logic [WIDTH-1:0]        r_imm;
    logic [3:0]              r_remain;
    logic [REGS-1:0][WIDTH-1:0] w_regs;
    logic                    w_accept;
    logic                    w_seq_wr;

    assign w_accept = (r_state == S_IDLE) && cmdValid;
    assign w_seq_wr = (r_state == S_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmdReady     = 1'b0;
        doneValid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmdReady = 1'b1;
                if (cmdValid) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD:  w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_WRITE;
            S_WRITE: w_state_next = (r_remain != 4'd0) ? S_EXEC : S_DONE;
            S_DONE: begin
                doneValid    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_func    <= '0;
            r_dst     <= '0;
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_use_imm <= 1'b0;
            r_imm     <= '0;
            r_remain  <= '0;
            aluFunc   <= '0;
            busA      <= '0;
            busB      <= '0;
            aluEn     <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_func    <= cmdFunc;
                        r_dst     <= cmdDst;
                        r_src_a   <= cmdSrcA;
                        r_src_b   <= cmdSrcB;
                        r_use_imm <= cmdUseImm;
                        r_imm     <= cmdImm;
                        r_remain  <= cmdCount;
                    end
                end
                S_LOAD: begin
                    busA    <= w_regs[r_src_a];
                    busB    <= r_use_imm ? r_imm : w_regs[r_src_b];
                    aluFunc <= r_func;
                    aluEn   <= 1'b1;
                end
                S_EXEC: begin
                    result <= busD;
                end
                S_WRITE: begin
                    zero <= (result == '0);
                    neg  <= result[WIDTH-1];
                    // A chained pass feeds the previous result back as operand A.
                    if (r_remain != 4'd0) begin
                        r_remain <= r_remain - 4'd1;
                        busA     <= result;
                    end
                end
                S_DONE: begin
                    aluEn <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Write-back takes priority over a host write to the same register.
    genvar gi;
    generate
        for (gi = 0; gi < REGS; gi++) begin : g_reg
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (w_seq_wr && (r_dst == AW'(gi))) begin
                    r_q <= result;
                end else if (wrEn && (wrAddr == AW'(gi))) begin
                    r_q <= wrData;
                end
            end
            assign w_regs[gi] = r_q;
        end
    endgenerate

    assign rdData = w_regs[rdAddr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU on the bus, shadow register file and
// a scoreboard of expected results popped at each doneValid pulse.
module tb_alu_sequencer;

    localparam int WIDTH = 16;
    localparam int REGS  = 8;
    localparam int AW    = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cmdValid = 1'b0;
    logic                    cmdReady;
    logic [3:0]              cmdFunc = '0;
    logic [AW-1:0]           cmdDst = '0;
    logic [AW-1:0]           cmdSrcA = '0;
    logic [AW-1:0]           cmdSrcB = '0;
    logic                    cmdUseImm = 1'b0;
    logic signed [WIDTH-1:0] cmdImm = '0;
    logic [3:0]              cmdCount = '0;
    logic                    wrEn = 1'b0;
    logic [AW-1:0]           wrAddr = '0;
    logic [WIDTH-1:0]        wrData = '0;
    logic [AW-1:0]           rdAddr = '0;
    logic [WIDTH-1:0]        rdData;
    logic [3:0]              aluFunc;
    logic signed [WIDTH-1:0] busA;
    logic signed [WIDTH-1:0] busB;
    logic                    aluEn;
    logic signed [WIDTH-1:0] busD;
    logic                    doneValid;
    logic [WIDTH-1:0]        result;
    logic                    zero;
    logic                    neg;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [AW-1:0]    dst;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] sh[REGS];
    int               checks = 0;
    int               errors = 0;

    alu_sequencer #(.WIDTH(WIDTH), .REGS(REGS)) dut (
        .clk(clk), .rst(rst),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdFunc(cmdFunc),
        .cmdDst(cmdDst), .cmdSrcA(cmdSrcA), .cmdSrcB(cmdSrcB),
        .cmdUseImm(cmdUseImm), .cmdImm(cmdImm), .cmdCount(cmdCount),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddr(rdAddr), .rdData(rdData),
        .aluFunc(aluFunc), .busA(busA), .busB(busB), .aluEn(aluEn), .busD(busD),
        .doneValid(doneValid), .result(result), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] f, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    always_comb busD = aluEn ? alu_f(aluFunc, busA, busB) : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wrEn = 1'b1; wrAddr = a; wrData = d;
        tick();
        wrEn = 1'b0;
        sh[a] = d;
    endtask

    // Pops the oldest expectation and compares it against the completed command.
    task automatic check_done(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL %s_sb got empty scoreboard exp entry", name);
            return;
        end
        e = sb.pop_front();
        sh[e.dst] = e.res;
        rdAddr = e.dst;
        #1;
        $display("txn %s dst=%0d result=%h exp=%h zero=%b neg=%b", name, e.dst, result, e.res, zero, neg);
        checks++;
        if (result !== e.res) begin errors++; $display("FAIL %s_result got %h exp %h", name, result, e.res); end
        checks++;
        if (rdData !== e.res) begin errors++; $display("FAIL %s_wb got %h exp %h", name, rdData, e.res); end
        checks++;
        if (zero !== (e.res == '0)) begin errors++; $display("FAIL %s_zero got %b exp %b", name, zero, e.res == '0); end
        checks++;
        if (neg !== e.res[WIDTH-1]) begin errors++; $display("FAIL %s_neg got %b exp %b", name, neg, e.res[WIDTH-1]); end
    endtask

    task automatic run_cmd(input string name, input logic [3:0] f, input logic [AW-1:0] dst,
                           input logic [AW-1:0] sa, input logic [AW-1:0] sbr, input logic use_imm,
                           input logic [WIDTH-1:0] imm, input logic [3:0] cnt, input bit collide,
                           input bit acc_wr, input logic [AW-1:0] acc_addr, input logic [WIDTH-1:0] acc_data);
        logic [WIDTH-1:0] ops[16];
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        int done_at;
        checks++;
        if (cmdReady !== 1'b1) begin errors++; $display("FAIL %s_ready got %b exp 1", name, cmdReady); end
        cmdFunc = f; cmdDst = dst; cmdSrcA = sa; cmdSrcB = sbr;
        cmdUseImm = use_imm; cmdImm = imm; cmdCount = cnt; cmdValid = 1'b1;
        if (acc_wr) begin
            wrEn = 1'b1; wrAddr = acc_addr; wrData = acc_data; sh[acc_addr] = acc_data;
        end
        ops[0] = sh[sa];
        b = use_imm ? imm : sh[sbr];
        for (int k = 1; k <= int'(cnt); k++) ops[k] = alu_f(f, ops[k-1], b);
        r = alu_f(f, ops[cnt], b);
        sb.push_back('{res: r, dst: dst});
        tick();
        cmdValid = 1'b0;
        wrEn = 1'b0;
        done_at = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            wrEn = 1'b0;
            if ((n % 2 == 1) && (n <= 2 * int'(cnt) + 1)) begin
                checks++;
                if (busA !== ops[(n-1)/2]) begin errors++; $display("FAIL %s_busA@%0d got %h exp %h", name, n, busA, ops[(n-1)/2]); end
                checks++;
                if (busB !== b) begin errors++; $display("FAIL %s_busB@%0d got %h exp %h", name, n, busB, b); end
                checks++;
                if ({aluEn, aluFunc} !== {1'b1, f}) begin errors++; $display("FAIL %s_alu@%0d got %b/%h exp 1/%h", name, n, aluEn, aluFunc, f); end
            end
            if (doneValid === 1'b1) begin
                done_at = n;
                break;
            end
            if (collide && n == 2) begin
                wrEn = 1'b1; wrAddr = dst; wrData = ~r;
            end
        end
        checks++;
        if (done_at != 3 + 2 * int'(cnt)) begin errors++; $display("FAIL %s_latency got %0d exp %0d", name, done_at, 3 + 2 * int'(cnt)); end
        check_done(name);
        tick();
        checks++;
        if ({aluEn, doneValid, cmdReady} !== 3'b001) begin
            errors++; $display("FAIL %s_finish got aluEn/done/ready=%b%b%b exp 001", name, aluEn, doneValid, cmdReady);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({aluEn, doneValid, cmdReady} !== 3'b001 || busA !== '0 || busB !== '0) begin
            errors++; $display("FAIL reset_out got aluEn/done/ready=%b%b%b busA=%h busB=%h exp 001 0 0", aluEn, doneValid, cmdReady, busA, busB);
        end
        for (int a = 0; a < REGS; a++) begin
            rdAddr = AW'(a);
            #1;
            checks++;
            if (rdData !== '0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0000", a, rdData); end
            sh[a] = '0;
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        host_write(3'd1, 16'd2);
        host_write(3'd2, 16'd3);
        run_cmd("basic", 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 3'd0, 16'd0);
    endtask

    task automatic test_immediate();
        run_cmd("imm", 4'd0, 3'd4, 3'd3, 3'd0, 1'b1, 16'hFFF9, 4'd0, 1'b0, 1'b0, 3'd0, 16'd0);
    endtask

    task automatic test_chained();
        run_cmd("chain", 4'd0, 3'd5, 3'd1, 3'd0, 1'b1, 16'd3, 4'd2, 1'b0, 1'b0, 3'd0, 16'd0);
    endtask

    task automatic test_zero();
        run_cmd("zero", 4'd1, 3'd7, 3'd2, 3'd2, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 3'd0, 16'd0);
    endtask

    task automatic test_collision();
        run_cmd("collide", 4'd4, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 3'd0, 16'd0);
    endtask

    task automatic test_back_to_back();
        int ready_at;
        int dones;
        checks++;
        if (cmdReady !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", cmdReady); end
        cmdFunc = 4'd0; cmdDst = 3'd6; cmdSrcA = 3'd1; cmdSrcB = 3'd2; cmdUseImm = 1'b0; cmdCount = 4'd0;
        cmdValid = 1'b1;
        sb.push_back('{res: alu_f(4'd0, sh[1], sh[2]), dst: 3'd6});
        tick();
        cmdFunc = 4'd1; cmdDst = 3'd7; cmdSrcA = 3'd6; cmdSrcB = 3'd1;
        ready_at = -1;
        dones = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (doneValid === 1'b1) begin
                dones++;
                checks++;
                if (n != 3) begin errors++; $display("FAIL b2b_lat1 got %0d exp 3", n); end
                check_done("b2b_first");
            end
            if (cmdReady === 1'b1) begin
                ready_at = n;
                break;
            end
        end
        checks++;
        if (ready_at != 4 || dones != 1) begin errors++; $display("FAIL b2b_busy got ready@%0d dones=%0d exp ready@4 dones=1", ready_at, dones); end
        sb.push_back('{res: alu_f(4'd1, sh[6], sh[1]), dst: 3'd7});
        tick();
        cmdValid = 1'b0;
        dones = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (doneValid === 1'b1) begin
                dones++;
                checks++;
                if (n != 3) begin errors++; $display("FAIL b2b_lat2 got %0d exp 3", n); end
                check_done("b2b_second");
            end
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL b2b_once got %0d exp 1", dones); end
    endtask

    task automatic test_accept_write();
        run_cmd("accwr_wrap", 4'd0, 3'd6, 3'd1, 3'd0, 1'b1, 16'd1, 4'd0, 1'b0, 1'b1, 3'd1, 16'h7FFF);
    endtask

    task automatic test_reset_mid();
        int dones;
        cmdFunc = 4'd0; cmdDst = 3'd0; cmdSrcA = 3'd1; cmdSrcB = 3'd2; cmdUseImm = 1'b0; cmdCount = 4'd0;
        cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
        tick();
        checks++;
        if (aluEn !== 1'b1) begin errors++; $display("FAIL rstmid_exec got aluEn=%b exp 1", aluEn); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({aluEn, cmdReady} !== 2'b01 || busA !== '0) begin
            errors++; $display("FAIL rstmid_async got aluEn/ready=%b%b busA=%h exp 01 0000", aluEn, cmdReady, busA);
        end
        tick();
        rst = 1'b0;
        sb.delete();
        for (int a = 0; a < REGS; a++) sh[a] = '0;
        dones = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (doneValid === 1'b1) dones++;
        end
        rdAddr = 3'd0;
        #1;
        checks++;
        if (dones != 0 || rdData !== '0 || cmdReady !== 1'b1) begin
            errors++; $display("FAIL rstmid_abandon got dones=%0d r0=%h ready=%b exp 0 0000 1", dones, rdData, cmdReady);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_immediate();
        test_chained();
        test_zero();
        test_collision();
        test_back_to_back();
        test_accept_write();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
